// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, default prices and seven-segment encodings
package vending_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VEND   = 2'b01,
    REFUND = 2'b10
  } state_e;
  localparam int DEF_PRICE_CHILD = 10;
  localparam int DEF_PRICE_MEN   = 12;
  localparam int DEF_PRICE_WOMEN = 15;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Active-low segment pattern for a decimal digit, dp off; non-decimal codes go blank
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/vending_machine_seg7_scan.sv
// seg7_scan: multiplexes a 0..99 value onto a 4-digit active-low seven-segment display
module seg7_scan
  import vending_pkg::*;
#(
  parameter int REFRESH_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] value_i,
  output logic [3:0] anode_o,
  output logic [7:0] segment_o
);
  logic [REFRESH_BITS-1:0] scan_q;
  logic [3:0] tens, units;
  logic [1:0] dig;
  // Free-running scan counter; its top two bits pick the lit digit
  always_ff @(posedge clk or posedge rst)
    if (rst) scan_q <= '0;
    else scan_q <= scan_q + REFRESH_BITS'(1);
  // Split into BCD and drive one anode; tens blanks below 10, upper digits always blank
  always_comb begin
    tens = 4'(value_i / 7'd10);
    units = 4'(value_i % 7'd10);
    dig = scan_q[REFRESH_BITS-1 -: 2];
    anode_o = ~(4'b0001 << dig);
    segment_o = dig == 2'd0 ? seg_digit(units) :
                dig == 2'd1 && tens != 4'd0 ? seg_digit(tens) : SEG_BLANK;
  end
endmodule

// File: rtl/vending_machine.sv
// vending_machine: coin credit, refund and service-selection FSM with display; VM_DEBOUNCE_EN adds button debouncing
module vending_machine
  import vending_pkg::*;
#(
  parameter int PRICE_CHILD  = DEF_PRICE_CHILD,
  parameter int PRICE_MEN    = DEF_PRICE_MEN,
  parameter int PRICE_WOMEN  = DEF_PRICE_WOMEN,
  parameter int HOLD_CYCLES  = 16,
  parameter int CREDIT_MAX   = 99,
  parameter int REFRESH_BITS = 4
`ifdef VM_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 2
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNC,
  input  logic       SW15,
  input  logic       SW14,
  input  logic       SW13,
  output logic       LED15,
  output logic       LED14,
  output logic       LED13,
  output logic [3:0] Anode_Activate,
  output logic [7:0] Segment
);
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  logic [3:0] btn_q, btn_s, prev_q, edge_w;
  state_e state, state_d;
  logic [6:0] credit_q, credit_d, change_q, change_d, sat, price, disp;
  logic [2:0] led_q, led_d, sel;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] coin_sum, acc;
  // Synchronise raw buttons, packed {L, R, D, C}
  always_ff @(posedge clk or posedge rst)
    if (rst) btn_q <= '0;
    else btn_q <= {BTNL, BTNR, BTND, BTNC};
`ifdef VM_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] db_q [4];
  // Count consecutive high cycles per button, saturating once the button counts as pressed
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 4; i++) db_q[i] <= '0;
    else for (int i = 0; i < 4; i++)
      db_q[i] <= !btn_q[i] ? '0 : db_q[i] == DW'(DEBOUNCE_CYCLES) ? db_q[i] : db_q[i] + DW'(1);
  // A button is pressed only once it has stayed high long enough
  always_comb for (int i = 0; i < 4; i++) btn_s[i] = db_q[i] == DW'(DEBOUNCE_CYCLES);
`else
  // Without debouncing the synchronised level is used directly
  always_comb btn_s = btn_q;
`endif
  // Previous level for rising-edge detection; tracked in every state so edges never queue
  always_ff @(posedge clk or posedge rst)
    if (rst) prev_q <= '0;
    else prev_q <= btn_s;
  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      led_q <= '0;
      timer_q <= '0;
    end else begin
      state <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      led_q <= led_d;
      timer_q <= timer_d;
    end
  // Next state: refund beats coins and selection; coins are summed and saturated before the price test
  always_comb begin
    state_d = state;
    credit_d = credit_q;
    change_d = change_q;
    led_d = led_q;
    timer_d = timer_q;
    edge_w = btn_s & ~prev_q;
    coin_sum = (edge_w[3] ? 8'd2 : 8'd0) + (edge_w[2] ? 8'd5 : 8'd0) + (edge_w[1] ? 8'd10 : 8'd0);
    acc = {1'b0, credit_q} + coin_sum;
    sat = acc > 8'(CREDIT_MAX) ? 7'(CREDIT_MAX) : acc[6:0];
    sel = SW15 ? 3'b100 : SW14 ? 3'b010 : SW13 ? 3'b001 : 3'b000;
    price = SW15 ? 7'(PRICE_CHILD) : SW14 ? 7'(PRICE_MEN) : 7'(PRICE_WOMEN);
    case (state)
      IDLE:
        if (edge_w[0] && credit_q != '0) begin
          state_d = REFUND;
          timer_d = TW'(HOLD_CYCLES - 1);
        end else begin
          credit_d = sat;
          if (sel != '0 && sat >= price) begin
            state_d = VEND;
            change_d = sat - price;
            led_d = sel;
            timer_d = TW'(HOLD_CYCLES - 1);
          end
        end
      VEND, REFUND:
        if (timer_q == '0) begin
          state_d = IDLE;
          credit_d = '0;
          led_d = '0;
        end else timer_d = timer_q - TW'(1);
      default: begin
        state_d = IDLE;
        credit_d = '0;
        led_d = '0;
      end
    endcase
    disp = state == VEND ? change_q : credit_q;
  end
  assign {LED15, LED14, LED13} = led_q;
  seg7_scan #(.REFRESH_BITS(REFRESH_BITS)) u_scan (
    .clk(clk),
    .rst(rst),
    .value_i(disp),
    .anode_o(Anode_Activate),
    .segment_o(Segment)
  );
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed scenarios checked every cycle against a behavioural model
module tb_vending_machine;
  logic clk = 0, rst = 1;
  logic BTNL = 0, BTNR = 0, BTND = 0, BTNC = 0, SW15 = 0, SW14 = 0, SW13 = 0;
  logic LED15, LED14, LED13;
  logic [3:0] an;
  logic [7:0] seg;
  int errors = 0, checks = 0;
  logic [7:0] enc [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  vending_machine dut (
    .clk(clk), .rst(rst),
    .BTNL(BTNL), .BTNR(BTNR), .BTND(BTND), .BTNC(BTNC),
    .SW15(SW15), .SW14(SW14), .SW13(SW13),
    .LED15(LED15), .LED14(LED14), .LED13(LED13),
    .Anode_Activate(an), .Segment(seg)
  );

  always #5 clk = ~clk;

  // Model state: 0 idle, 1 vend, 2 refund; h1/h2 are the raw {L,R,D,C} seen one and two edges ago
  int m_credit = 0, m_change = 0, m_state = 0, m_cnt = 0, m_sc = 0;
  logic [2:0] m_led = 0;
  logic [3:0] h1 = 0, h2 = 0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] e;
    int c, price;
    if (rst) begin
      m_credit = 0; m_change = 0; m_state = 0; m_cnt = 0; m_sc = 0; m_led = 0; h1 = 0; h2 = 0;
    end else begin
      e = h1 & ~h2;
      m_sc = (m_sc + 1) % 16;
      if (m_state == 0) begin
        if (e[0] && m_credit > 0) begin
          m_state = 2; m_cnt = 16;
        end else begin
          c = m_credit + (e[3] ? 2 : 0) + (e[2] ? 5 : 0) + (e[1] ? 10 : 0);
          if (c > 99) c = 99;
          m_credit = c;
          price = SW15 ? 10 : SW14 ? 12 : SW13 ? 15 : 0;
          if (price > 0 && c >= price) begin
            m_state = 1; m_cnt = 16; m_change = c - price;
            m_led = SW15 ? 3'b100 : SW14 ? 3'b010 : 3'b001;
          end
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin m_state = 0; m_credit = 0; m_led = 0; end
      end
      h2 = h1;
      h1 = {BTNL, BTNR, BTND, BTNC};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset: LEDs, anodes and segments against the model
  always @(negedge clk) if (!rst) begin
    int v, d;
    logic [7:0] es;
    v = m_state == 1 ? m_change : m_credit;
    d = m_sc / 4;
    es = d == 0 ? enc[v % 10] : d == 1 ? (v < 10 ? 8'hFF : enc[v / 10]) : 8'hFF;
    chk("leds", {LED15, LED14, LED13}, m_state == 1 ? m_led : 3'b000);
    chk("anode", an, d == 0 ? 4'b1110 : d == 1 ? 4'b1101 : d == 2 ? 4'b1011 : 4'b0111);
    chk("segment", seg, es);
  end

  function automatic int dec(input logic [7:0] s);
    if (s == 8'hFF) return 0;
    for (int i = 0; i < 10; i++) if (enc[i] == s) return i;
    return -1000;
  endfunction

  // Decode the displayed number over one full scan period
  task automatic chk_val(input string name, input int exp);
    logic [7:0] u, t;
    u = 8'h00; t = 8'h00;
    repeat (16) begin
      @(negedge clk);
      if (an == 4'b1110) u = seg;
      if (an == 4'b1101) t = seg;
    end
    chk(name, dec(t) * 10 + dec(u), exp);
  endtask

  task automatic press(input logic [3:0] m);
    @(posedge clk); #1 {BTNL, BTNR, BTND, BTNC} = m;
    @(posedge clk); #1 {BTNL, BTNR, BTND, BTNC} = 4'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Switch held for one edge; on return a successful selection has just entered VEND
  task automatic pick(input logic [2:0] s);
    @(posedge clk); #1 {SW15, SW14, SW13} = s;
    @(posedge clk); #1 {SW15, SW14, SW13} = 3'b0;
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", {LED15, LED14, LED13}, 3'b000);
    chk("rst_anode", an, 4'b1110);
    chk("rst_seg", seg, 8'hC0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    // Refund of 19
    press(4'b1000);
    chk_val("credit_2", 2);
    press(4'b1110);
    chk_val("credit_19", 19);
    chk("model_credit_19", m_credit, 19);
    @(posedge clk); #1 BTNC = 1;
    @(posedge clk); #1 BTNC = 0;
    @(posedge clk); #1;
    chk_val("refund_disp", 19);
    repeat (4) @(posedge clk);
    #1;
    chk_val("after_refund", 0);
    chk("model_after_refund", m_credit, 0);
    // Zero-credit refund is ignored
    press(4'b0001);
    chk_val("refund_zero", 0);
    // Child, after a rejected men selection
    press(4'b0010);
    pick(3'b010);
    chk("men_rejected_leds", {LED15, LED14, LED13}, 3'b000);
    chk_val("credit_kept_10", 10);
    pick(3'b100);
    chk("child_led", {LED15, LED14, LED13}, 3'b100);
    chk_val("child_change", 0);
    settle();
    chk_val("child_done", 0);
    // Men exact
    press(4'b1010);
    pick(3'b010);
    chk("men_led", {LED15, LED14, LED13}, 3'b010);
    chk_val("men_change", 0);
    settle();
    // Women exact
    press(4'b0110);
    pick(3'b001);
    chk("women_led", {LED15, LED14, LED13}, 3'b001);
    chk_val("women_change", 0);
    settle();
    // Child with change 5; priority SW15 over SW13
    press(4'b0110);
    pick(3'b101);
    chk("child5_led", {LED15, LED14, LED13}, 3'b100);
    chk("model_change_5", m_change, 5);
    chk_val("child5_change", 5);
    settle();
    chk_val("child5_done", 0);
    // Saturation at 99 then reset mid-vend
    repeat (11) press(4'b0010);
    chk_val("sat_99", 99);
    chk("model_sat_99", m_credit, 99);
    pick(3'b001);
    chk("sat_vend_led", {LED15, LED14, LED13}, 3'b001);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_leds", {LED15, LED14, LED13}, 3'b000);
    chk("midrst_anode", an, 4'b1110);
    chk("midrst_seg", seg, 8'hC0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    press(4'b1000);
    chk_val("post_rst_credit", 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
